// File: rtl/pdp8_pkg.sv
// Shared PDP-8 word/address widths plus the memory arbiter's encodings and defaults.
package pdp8_pkg;
    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 12;

    localparam int ARB_RD_LAT         = 1;
    localparam int ARB_IFU_STARVE_MAX = 4;

    // Bit positions inside the one-hot grant vector produced by pdp8_arb_pick.
    localparam int GNT_IFU_RD  = 0;
    localparam int GNT_EXEC_RD = 1;
    localparam int GNT_EXEC_WR = 2;
    localparam int GNT_W       = 3;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IFU  = 2'd1,
        SRC_EXEC = 2'd2
    } arb_src_e;
endpackage

// File: rtl/pdp8_mem_arbiter_if.sv
// Request/grant/return bundle between the IFU, the execution unit, the arbiter and memory.
interface pdp8_mem_arbiter_if;
    logic                             ifu_rd_req;
    logic [pdp8_pkg::ADDR_WIDTH-1:0]  ifu_rd_addr;
    logic                             ifu_rd_gnt;
    logic                             ifu_rd_valid;
    logic [pdp8_pkg::DATA_WIDTH-1:0]  ifu_rd_data;

    logic                             exec_rd_req;
    logic [pdp8_pkg::ADDR_WIDTH-1:0]  exec_rd_addr;
    logic                             exec_rd_gnt;
    logic                             exec_rd_valid;
    logic [pdp8_pkg::DATA_WIDTH-1:0]  exec_rd_data;

    logic                             exec_wr_req;
    logic [pdp8_pkg::ADDR_WIDTH-1:0]  exec_wr_addr;
    logic [pdp8_pkg::DATA_WIDTH-1:0]  exec_wr_data;
    logic                             exec_wr_gnt;

    logic                             mem_req;
    logic                             mem_we;
    logic [pdp8_pkg::ADDR_WIDTH-1:0]  mem_addr;
    logic [pdp8_pkg::DATA_WIDTH-1:0]  mem_wdata;
    logic [pdp8_pkg::DATA_WIDTH-1:0]  mem_rdata;

    // The arbiter's view: requests and memory read data come in, grants and commands go out.
    modport slave (
        input  ifu_rd_req, ifu_rd_addr,
        input  exec_rd_req, exec_rd_addr,
        input  exec_wr_req, exec_wr_addr, exec_wr_data,
        input  mem_rdata,
        output ifu_rd_gnt, ifu_rd_valid, ifu_rd_data,
        output exec_rd_gnt, exec_rd_valid, exec_rd_data,
        output exec_wr_gnt,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ifu_rd_req, ifu_rd_addr,
        output exec_rd_req, exec_rd_addr,
        output exec_wr_req, exec_wr_addr, exec_wr_data,
        output mem_rdata,
        input  ifu_rd_gnt, ifu_rd_valid, ifu_rd_data,
        input  exec_rd_gnt, exec_rd_valid, exec_rd_data,
        input  exec_wr_gnt,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/pdp8_arb_pick.sv
// Combinational winner pick: exec write > exec read > IFU read, unless the IFU is starved.
module pdp8_arb_pick
    import pdp8_pkg::*;
#(
    parameter int IFU_STARVE_MAX = ARB_IFU_STARVE_MAX
) (
    input  logic             enable,
    input  logic             ifu_rd_req,
    input  logic             exec_rd_req,
    input  logic             exec_wr_req,
    input  logic [2:0]       starve_cnt,
    output logic [GNT_W-1:0] gnt
);
    always_comb begin
        gnt = '0;
        if (enable) begin
            if (ifu_rd_req && (starve_cnt == 3'(IFU_STARVE_MAX))) begin
                gnt[GNT_IFU_RD] = 1'b1;
            end else if (exec_wr_req) begin
                gnt[GNT_EXEC_WR] = 1'b1;
            end else if (exec_rd_req) begin
                gnt[GNT_EXEC_RD] = 1'b1;
            end else if (ifu_rd_req) begin
                gnt[GNT_IFU_RD] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pdp8_mem_arbiter.sv
// Single-port PDP-8 memory arbiter: grants one access at a time and steers fixed-latency
// read data back to whichever requester issued the read.
module pdp8_mem_arbiter
    import pdp8_pkg::*;
#(
    parameter int RD_LAT         = ARB_RD_LAT,
    parameter int IFU_STARVE_MAX = ARB_IFU_STARVE_MAX
) (
    input logic               clk,
    input logic               reset_n,
    pdp8_mem_arbiter_if.slave bus
);
    localparam int         LAT_W       = $clog2(RD_LAT + 1);
    localparam logic [0:0] ST_IDLE     = ARB_IDLE;
    localparam logic [0:0] ST_RD_WAIT  = ARB_RD_WAIT;

    logic [0:0]            state;
    logic [LAT_W-1:0]      lat_cnt;
    logic [2:0]            starve_cnt;
    arb_src_e              rd_src;
    logic                  arb_en;
    logic [GNT_W-1:0]      gnt;
    logic                  rd_grant;
    logic                  exec_grant;
    logic                  ifu_valid_q;
    logic                  exec_valid_q;
    logic [DATA_WIDTH-1:0] ifu_data_q;
    logic [DATA_WIDTH-1:0] exec_data_q;

    assign arb_en     = reset_n && (state == ST_IDLE);
    assign rd_grant   = gnt[GNT_IFU_RD] || gnt[GNT_EXEC_RD];
    assign exec_grant = gnt[GNT_EXEC_RD] || gnt[GNT_EXEC_WR];

    pdp8_arb_pick #(
        .IFU_STARVE_MAX(IFU_STARVE_MAX)
    ) u_pick (
        .enable     (arb_en),
        .ifu_rd_req (bus.ifu_rd_req),
        .exec_rd_req(bus.exec_rd_req),
        .exec_wr_req(bus.exec_wr_req),
        .starve_cnt (starve_cnt),
        .gnt        (gnt)
    );

    always_comb begin
        bus.ifu_rd_gnt  = gnt[GNT_IFU_RD];
        bus.exec_rd_gnt = gnt[GNT_EXEC_RD];
        bus.exec_wr_gnt = gnt[GNT_EXEC_WR];
        bus.mem_req     = |gnt;
        bus.mem_we      = gnt[GNT_EXEC_WR];
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        if (gnt[GNT_EXEC_WR]) begin
            bus.mem_addr  = bus.exec_wr_addr;
            bus.mem_wdata = bus.exec_wr_data;
        end else if (gnt[GNT_EXEC_RD]) begin
            bus.mem_addr = bus.exec_rd_addr;
        end else if (gnt[GNT_IFU_RD]) begin
            bus.mem_addr = bus.ifu_rd_addr;
        end
    end

    assign bus.ifu_rd_valid  = ifu_valid_q;
    assign bus.ifu_rd_data   = ifu_data_q;
    assign bus.exec_rd_valid = exec_valid_q;
    assign bus.exec_rd_data  = exec_data_q;

    // Read data is captured on the edge where the latency count runs out, so the
    // valid pulse lands in the first idle cycle and can overlap the next grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            lat_cnt      <= '0;
            rd_src       <= SRC_NONE;
            ifu_valid_q  <= 1'b0;
            exec_valid_q <= 1'b0;
            ifu_data_q   <= '0;
            exec_data_q  <= '0;
        end else begin
            ifu_valid_q  <= 1'b0;
            exec_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_grant) begin
                        state   <= ST_RD_WAIT;
                        lat_cnt <= LAT_W'(RD_LAT);
                        rd_src  <= gnt[GNT_IFU_RD] ? SRC_IFU : SRC_EXEC;
                    end
                end
                ST_RD_WAIT: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (lat_cnt == LAT_W'(1)) begin
                        state  <= ST_IDLE;
                        rd_src <= SRC_NONE;
                        if (rd_src == SRC_IFU) begin
                            ifu_data_q  <= bus.mem_rdata;
                            ifu_valid_q <= 1'b1;
                        end else if (rd_src == SRC_EXEC) begin
                            exec_data_q  <= bus.mem_rdata;
                            exec_valid_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Counts exec wins the waiting IFU has lost; saturating here lets the pick force the IFU.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!bus.ifu_rd_req || gnt[GNT_IFU_RD]) begin
            starve_cnt <= '0;
        end else if (exec_grant && (starve_cnt != 3'(IFU_STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// Bench for pdp8_mem_arbiter: directed timing scenarios plus a randomized run against a cycle-count model.
module tb_pdp8_mem_arbiter;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   tests   = 0;
    int   fails   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pdp8_mem_arbiter_if bus1();
    pdp8_mem_arbiter_if bus3();

    pdp8_mem_arbiter #(.RD_LAT(1), .IFU_STARVE_MAX(4)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    pdp8_mem_arbiter #(.RD_LAT(3), .IFU_STARVE_MAX(4)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

    // Memory for the RD_LAT=1 instance: a real array with one cycle of read latency.
    logic [11:0] mem1 [0:4095];
    logic        p1_v = 1'b0;
    logic [11:0] p1_a = '0;
    always @(posedge clk) begin
        p1_v <= bus1.mem_req && !bus1.mem_we;
        p1_a <= bus1.mem_addr;
        if (bus1.mem_req && bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
    end
    assign bus1.mem_rdata = p1_v ? mem1[p1_a] : 12'o5555;

    // Memory for the RD_LAT=3 instance returns the complemented address three cycles on.
    logic [2:0]  p3_v = '0;
    logic [11:0] p3_a [0:2];
    always @(posedge clk) begin
        p3_v    <= {p3_v[1:0], bus3.mem_req && !bus3.mem_we};
        p3_a[0] <= bus3.mem_addr;
        p3_a[1] <= p3_a[0];
        p3_a[2] <= p3_a[1];
    end
    assign bus3.mem_rdata = p3_v[2] ? ~p3_a[2] : 12'o1111;

    function automatic logic [4:0] ctl1();
        return {bus1.ifu_rd_gnt, bus1.exec_rd_gnt, bus1.exec_wr_gnt, bus1.mem_req, bus1.mem_we};
    endfunction

    function automatic logic [4:0] ctl3();
        return {bus3.ifu_rd_gnt, bus3.exec_rd_gnt, bus3.exec_wr_gnt, bus3.mem_req, bus3.mem_we};
    endfunction

    task automatic clear_inputs();
        bus1.ifu_rd_req  = 1'b0; bus1.ifu_rd_addr  = '0;
        bus1.exec_rd_req = 1'b0; bus1.exec_rd_addr = '0;
        bus1.exec_wr_req = 1'b0; bus1.exec_wr_addr = '0; bus1.exec_wr_data = '0;
        bus3.ifu_rd_req  = 1'b0; bus3.ifu_rd_addr  = '0;
        bus3.exec_rd_req = 1'b0; bus3.exec_rd_addr = '0;
        bus3.exec_wr_req = 1'b0; bus3.exec_wr_addr = '0; bus3.exec_wr_data = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        bus1.ifu_rd_req  = 1'b1; bus1.ifu_rd_addr  = 12'o0777;
        bus1.exec_rd_req = 1'b1; bus1.exec_rd_addr = 12'o0003;
        bus1.exec_wr_req = 1'b1; bus1.exec_wr_addr = 12'o0001; bus1.exec_wr_data = 12'o0002;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({ctl1(), bus1.mem_addr, bus1.mem_wdata} !== 29'd0) begin
            fails++;
            $display("[TB] FAIL reset_forces_idle: ctl=%b addr=%o wdata=%o, expected all zero",
                     ctl1(), bus1.mem_addr, bus1.mem_wdata);
        end
        tests++;
        if ({bus1.ifu_rd_valid, bus1.exec_rd_valid, bus1.ifu_rd_data, bus1.exec_rd_data,
             bus3.ifu_rd_valid, bus3.exec_rd_valid, bus3.ifu_rd_data, bus3.exec_rd_data} !== 52'd0) begin
            fails++;
            $display("[TB] FAIL reset_returns: v1=%b%b d1=%o/%o v3=%b%b d3=%o/%o, expected all zero",
                     bus1.ifu_rd_valid, bus1.exec_rd_valid, bus1.ifu_rd_data, bus1.exec_rd_data,
                     bus3.ifu_rd_valid, bus3.exec_rd_valid, bus3.ifu_rd_data, bus3.exec_rd_data);
        end
        next_cycle();
        reset_n = 1'b1;
        clear_inputs();
        @(negedge clk);
        tests++;
        if ({ctl1(), ctl3(), bus1.mem_addr} !== 22'd0) begin
            fails++;
            $display("[TB] FAIL idle_no_request: ctl1=%b ctl3=%b addr=%o, expected zero",
                     ctl1(), ctl3(), bus1.mem_addr);
        end
    endtask

    task automatic test_ifu_read();
        // Seed the word first through the arbiter's own write path.
        next_cycle();
        bus1.exec_wr_req = 1'b1; bus1.exec_wr_addr = 12'o0200; bus1.exec_wr_data = 12'o7300;
        @(negedge clk);
        tests++;
        if ({ctl1(), bus1.mem_addr, bus1.mem_wdata} !== {5'b00111, 12'o0200, 12'o7300}) begin
            fails++;
            $display("[TB] FAIL seed_write: ctl=%b addr=%o wdata=%o, expected 00111 0200 7300",
                     ctl1(), bus1.mem_addr, bus1.mem_wdata);
        end
        next_cycle();
        bus1.exec_wr_req = 1'b0;
        bus1.ifu_rd_req  = 1'b1; bus1.ifu_rd_addr = 12'o0200;
        @(negedge clk);
        tests++;
        if ({ctl1(), bus1.mem_addr, bus1.mem_wdata} !== {5'b10010, 12'o0200, 12'o0000}) begin
            fails++;
            $display("[TB] FAIL ifu_grant: ctl=%b addr=%o wdata=%o, expected 10010 0200 0000",
                     ctl1(), bus1.mem_addr, bus1.mem_wdata);
        end
        next_cycle();
        bus1.ifu_rd_req = 1'b0;
        @(negedge clk);
        tests++;
        if ({ctl1(), bus1.ifu_rd_valid} !== 6'd0) begin
            fails++;
            $display("[TB] FAIL ifu_wait_cycle: ctl=%b valid=%b, expected 0", ctl1(), bus1.ifu_rd_valid);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if ({bus1.ifu_rd_valid, bus1.ifu_rd_data} !== {1'b1, 12'o7300}) begin
            fails++;
            $display("[TB] FAIL ifu_return: valid=%b data=%o, expected 1 7300",
                     bus1.ifu_rd_valid, bus1.ifu_rd_data);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if ({bus1.ifu_rd_valid, bus1.ifu_rd_data} !== {1'b0, 12'o7300}) begin
            fails++;
            $display("[TB] FAIL ifu_hold: valid=%b data=%o, expected 0 7300",
                     bus1.ifu_rd_valid, bus1.ifu_rd_data);
        end
    endtask

    task automatic test_wr_ifu_collide();
        next_cycle();
        bus1.ifu_rd_req  = 1'b1; bus1.ifu_rd_addr  = 12'o0300;
        bus1.exec_wr_req = 1'b1; bus1.exec_wr_addr = 12'o0050; bus1.exec_wr_data = 12'o1234;
        @(negedge clk);
        tests++;
        if ({ctl1(), bus1.mem_addr, bus1.mem_wdata} !== {5'b00111, 12'o0050, 12'o1234}) begin
            fails++;
            $display("[TB] FAIL collide_write_first: ctl=%b addr=%o wdata=%o, expected 00111 0050 1234",
                     ctl1(), bus1.mem_addr, bus1.mem_wdata);
        end
        next_cycle();
        bus1.exec_wr_req = 1'b0;
        @(negedge clk);
        tests++;
        if ({ctl1(), bus1.mem_addr} !== {5'b10010, 12'o0300}) begin
            fails++;
            $display("[TB] FAIL collide_ifu_next: ctl=%b addr=%o, expected 10010 0300", ctl1(), bus1.mem_addr);
        end
        next_cycle();
        bus1.ifu_rd_req = 1'b0;
        next_cycle();
        @(negedge clk);
        tests++;
        if (bus1.ifu_rd_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL collide_ifu_valid: valid=%b, expected 1", bus1.ifu_rd_valid);
        end
    endtask

    task automatic test_rd_wr_together();
        next_cycle();
        bus1.exec_rd_req = 1'b1; bus1.exec_rd_addr = 12'o0050;
        bus1.exec_wr_req = 1'b1; bus1.exec_wr_addr = 12'o0060; bus1.exec_wr_data = 12'o4321;
        @(negedge clk);
        tests++;
        if ({ctl1(), bus1.mem_addr, bus1.mem_wdata} !== {5'b00111, 12'o0060, 12'o4321}) begin
            fails++;
            $display("[TB] FAIL rdwr_write_first: ctl=%b addr=%o wdata=%o, expected 00111 0060 4321",
                     ctl1(), bus1.mem_addr, bus1.mem_wdata);
        end
        next_cycle();
        bus1.exec_wr_req = 1'b0;
        @(negedge clk);
        tests++;
        if ({ctl1(), bus1.mem_addr, bus1.mem_wdata} !== {5'b01010, 12'o0050, 12'o0000}) begin
            fails++;
            $display("[TB] FAIL rdwr_read_next: ctl=%b addr=%o wdata=%o, expected 01010 0050 0000",
                     ctl1(), bus1.mem_addr, bus1.mem_wdata);
        end
        next_cycle();
        bus1.exec_rd_req = 1'b0;
        @(negedge clk);
        tests++;
        if (bus1.exec_rd_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rdwr_early_valid: valid=%b, expected 0", bus1.exec_rd_valid);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if ({bus1.exec_rd_valid, bus1.ifu_rd_valid, bus1.exec_rd_data} !== {2'b10, 12'o1234}) begin
            fails++;
            $display("[TB] FAIL rdwr_exec_return: ev=%b iv=%b data=%o, expected 1 0 1234",
                     bus1.exec_rd_valid, bus1.ifu_rd_valid, bus1.exec_rd_data);
        end
    endtask

    task automatic test_starvation();
        int wr_cnt = 0;
        int ifu_at = 0;
        for (int k = 1; k <= 8 && ifu_at == 0; k++) begin
            next_cycle();
            bus1.ifu_rd_req  = 1'b1; bus1.ifu_rd_addr = 12'o0400;
            bus1.exec_wr_req = 1'b1;
            bus1.exec_wr_addr = 12'o0100 + 12'(k);
            bus1.exec_wr_data = 12'(k);
            @(negedge clk);
            if (bus1.exec_wr_gnt) wr_cnt++;
            if (bus1.ifu_rd_gnt) ifu_at = k;
        end
        tests++;
        if (wr_cnt != 4 || ifu_at != 5) begin
            fails++;
            $display("[TB] FAIL starve_override: writes=%0d ifu_at=%0d, expected 4 writes then ifu at 5",
                     wr_cnt, ifu_at);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if ({dut1.starve_cnt, ctl1()} !== 8'd0) begin
            fails++;
            $display("[TB] FAIL starve_clear: starve_cnt=%0d ctl=%b, expected 0 00000", dut1.starve_cnt, ctl1());
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if ({ctl1(), bus1.ifu_rd_valid} !== {5'b00111, 1'b1}) begin
            fails++;
            $display("[TB] FAIL starve_after: ctl=%b ifu_valid=%b, expected 00111 1", ctl1(), bus1.ifu_rd_valid);
        end
        next_cycle();
        clear_inputs();
        repeat (2) next_cycle();
    endtask

    task automatic test_lat3();
        int busy = 0;
        int early_valid = 0;
        next_cycle();
        bus3.ifu_rd_req = 1'b1; bus3.ifu_rd_addr = 12'o0123;
        @(negedge clk);
        tests++;
        if ({ctl3(), bus3.mem_addr} !== {5'b10010, 12'o0123}) begin
            fails++;
            $display("[TB] FAIL lat3_grant: ctl=%b addr=%o, expected 10010 0123", ctl3(), bus3.mem_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            bus3.ifu_rd_req  = 1'b0;
            bus3.exec_rd_req = 1'b1; bus3.exec_rd_addr = 12'o0555;
            @(negedge clk);
            if (ctl3() != 5'd0) busy++;
            if (bus3.ifu_rd_valid) early_valid++;
        end
        tests++;
        if (busy != 0 || early_valid != 0) begin
            fails++;
            $display("[TB] FAIL lat3_quiet: grant cycles=%0d early valids=%0d, expected 0 0", busy, early_valid);
        end
        next_cycle();
        @(negedge clk);
        tests++;
        if ({bus3.ifu_rd_valid, bus3.ifu_rd_data, ctl3(), bus3.mem_addr} !==
            {1'b1, ~12'o0123, 5'b01010, 12'o0555}) begin
            fails++;
            $display("[TB] FAIL lat3_return: valid=%b data=%o ctl=%b addr=%o, expected 1 %o 01010 0555",
                     bus3.ifu_rd_valid, bus3.ifu_rd_data, ctl3(), bus3.mem_addr, ~12'o0123);
        end
        next_cycle();
        bus3.exec_rd_req = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        tests++;
        if ({bus3.exec_rd_valid, bus3.exec_rd_data} !== {1'b1, ~12'o0555}) begin
            fails++;
            $display("[TB] FAIL lat3_exec_return: valid=%b data=%o, expected 1 %o",
                     bus3.exec_rd_valid, bus3.exec_rd_data, ~12'o0555);
        end
    endtask

    task automatic test_reset_during_wait();
        int ghost = 0;
        next_cycle();
        bus1.ifu_rd_req = 1'b1; bus1.ifu_rd_addr = 12'o0200;
        @(negedge clk);
        tests++;
        if (ctl1() !== 5'b10010) begin
            fails++;
            $display("[TB] FAIL rst_wait_grant: ctl=%b, expected 10010", ctl1());
        end
        next_cycle();
        reset_n = 1'b0;
        bus1.ifu_rd_req  = 1'b0;
        bus1.exec_wr_req = 1'b1; bus1.exec_wr_addr = 12'o0700; bus1.exec_wr_data = 12'o7777;
        next_cycle();
        @(negedge clk);
        tests++;
        if ({ctl1(), bus1.mem_addr, bus1.mem_wdata, bus1.ifu_rd_valid, bus1.ifu_rd_data,
             bus1.exec_rd_valid, bus1.exec_rd_data} !== 55'd0) begin
            fails++;
            $display("[TB] FAIL rst_wait_outputs: ctl=%b addr=%o iv=%b id=%o ev=%b ed=%o, expected all zero",
                     ctl1(), bus1.mem_addr, bus1.ifu_rd_valid, bus1.ifu_rd_data,
                     bus1.exec_rd_valid, bus1.exec_rd_data);
        end
        next_cycle();
        reset_n = 1'b1;
        bus1.exec_wr_req = 1'b0;
        @(negedge clk);
        if (bus1.ifu_rd_valid) ghost++;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            if (bus1.ifu_rd_valid) ghost++;
        end
        tests++;
        if (ghost != 0) begin
            fails++;
            $display("[TB] FAIL rst_dropped_read: valid pulses=%0d, expected 0", ghost);
        end
        next_cycle();
        bus1.ifu_rd_req = 1'b1; bus1.ifu_rd_addr = 12'o0050;
        @(negedge clk);
        tests++;
        if ({ctl1(), bus1.mem_addr} !== {5'b10010, 12'o0050}) begin
            fails++;
            $display("[TB] FAIL rst_first_grant: ctl=%b addr=%o, expected 10010 0050", ctl1(), bus1.mem_addr);
        end
        next_cycle();
        bus1.ifu_rd_req = 1'b0;
        next_cycle();
        @(negedge clk);
        tests++;
        if ({bus1.ifu_rd_valid, bus1.ifu_rd_data} !== {1'b1, 12'o1234}) begin
            fails++;
            $display("[TB] FAIL rst_first_return: valid=%b data=%o, expected 1 1234",
                     bus1.ifu_rd_valid, bus1.ifu_rd_data);
        end
    endtask

    // Model: the port is free from a cycle number onward; a read occupies it for RD_LAT+1
    // cycles and its data is due at issue+RD_LAT+1, taken from the model's memory image.
    task automatic test_random();
        logic [11:0] ref_mem [int];
        int          next_free = 0;
        int          ret_cyc   = -1;
        int          ret_src   = 0;
        logic        ret_known = 1'b0;
        logic [11:0] ret_data  = '0;
        int          starve    = 0;
        int          win       = 0;
        int          last_win  = 0;
        logic [11:0] ea, ed;
        logic [28:0] exp_v, obs_v;
        for (int n = 0; n < 400; n++) begin
            next_cycle();
            if (last_win == 1) bus1.ifu_rd_req  = 1'b0;
            if (last_win == 2) bus1.exec_rd_req = 1'b0;
            if (last_win == 3) bus1.exec_wr_req = 1'b0;
            if (!bus1.ifu_rd_req) begin
                if ($urandom_range(2) == 0) begin
                    bus1.ifu_rd_req  = 1'b1;
                    bus1.ifu_rd_addr = 12'o2000 + 12'($urandom_range(15));
                end
            end else if ($urandom_range(15) == 0) bus1.ifu_rd_req = 1'b0;
            if (!bus1.exec_rd_req) begin
                if ($urandom_range(2) == 0) begin
                    bus1.exec_rd_req  = 1'b1;
                    bus1.exec_rd_addr = 12'o2000 + 12'($urandom_range(15));
                end
            end else if ($urandom_range(15) == 0) bus1.exec_rd_req = 1'b0;
            if (!bus1.exec_wr_req) begin
                if ($urandom_range(2) == 0) begin
                    bus1.exec_wr_req  = 1'b1;
                    bus1.exec_wr_addr = 12'o2000 + 12'($urandom_range(15));
                    bus1.exec_wr_data = 12'($urandom_range(4095));
                end
            end else if ($urandom_range(15) == 0) bus1.exec_wr_req = 1'b0;

            @(negedge clk);
            win = 0;
            if (cyc >= next_free) begin
                if (bus1.ifu_rd_req && starve == 4) win = 1;
                else if (bus1.exec_wr_req)          win = 3;
                else if (bus1.exec_rd_req)          win = 2;
                else if (bus1.ifu_rd_req)           win = 1;
            end
            ea = (win == 3) ? bus1.exec_wr_addr : (win == 2) ? bus1.exec_rd_addr :
                 (win == 1) ? bus1.ifu_rd_addr : 12'o0000;
            ed = (win == 3) ? bus1.exec_wr_data : 12'o0000;
            exp_v = {win == 1, win == 2, win == 3, win != 0, win == 3, ea, ed};
            obs_v = {ctl1(), bus1.mem_addr, bus1.mem_wdata};
            tests++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("[TB] FAIL rand_cmd cyc=%0d: ctl/addr/wdata=%b/%o/%o, expected %b/%o/%o",
                         cyc, obs_v[28:24], obs_v[23:12], obs_v[11:0], exp_v[28:24], exp_v[23:12], exp_v[11:0]);
            end
            tests++;
            if ({bus1.ifu_rd_valid, bus1.exec_rd_valid} !==
                {(cyc == ret_cyc) && (ret_src == 1), (cyc == ret_cyc) && (ret_src == 2)}) begin
                fails++;
                $display("[TB] FAIL rand_valid cyc=%0d: ifu/exec valid=%b%b, expected %b%b", cyc,
                         bus1.ifu_rd_valid, bus1.exec_rd_valid,
                         (cyc == ret_cyc) && (ret_src == 1), (cyc == ret_cyc) && (ret_src == 2));
            end
            if (cyc == ret_cyc && ret_known) begin
                tests++;
                if (((ret_src == 1) ? bus1.ifu_rd_data : bus1.exec_rd_data) !== ret_data) begin
                    fails++;
                    $display("[TB] FAIL rand_data cyc=%0d: data=%o, expected %o", cyc,
                             (ret_src == 1) ? bus1.ifu_rd_data : bus1.exec_rd_data, ret_data);
                end
            end
            if (win == 3) ref_mem[int'(ea)] = ed;
            if (win == 1 || win == 2) begin
                next_free = cyc + 2;
                ret_cyc   = cyc + 2;
                ret_src   = win;
                ret_known = ref_mem.exists(int'(ea));
                ret_data  = ret_known ? ref_mem[int'(ea)] : 12'o0000;
            end
            if (!bus1.ifu_rd_req || win == 1) starve = 0;
            else if ((win == 2 || win == 3) && starve < 4) starve++;
            last_win = win;
        end
        next_cycle();
        clear_inputs();
        repeat (3) next_cycle();
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_wr_ifu_collide();
        test_rd_wr_together();
        test_starvation();
        test_lat3();
        test_reset_during_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
